pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised pipeline stage register for the 20-bit MIPS datapath (MEM->WB and peers).
//  Carries a data bundle plus a control-bit vector through one stage under a valid/ready
//  handshake, with flush (squash), backpressure and an optional 2-entry skid buffer that
//  breaks the combinational ready path. Counts backpressure cycles for performance debug.
// PARAMETERS
//  DATA_W  180  concatenated datapath payload width (9 x 20-bit fields in the WB stage)
//  CTRL_W  6    control-bit vector width; bit layout comes from pipe_pkg
//  SKID    1    0 = single register, combinational ready; 1 = 2-entry skid, registered ready
//  CNT_W   16   stall counter width
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       asynchronous, active-high reset
//  flush        in   1       squash all held entries this cycle
//  in_valid     in   1       upstream entry valid
//  in_ready     out  1       stage can accept; transfer when in_valid & in_ready
//  in_data      in   DATA_W  upstream payload
//  in_ctrl      in   CTRL_W  upstream control bits
//  out_valid    out  1       head entry valid
//  out_ready    in   1       downstream accepts; transfer when out_valid & out_ready
//  out_data     out  DATA_W  head payload
//  out_ctrl     out  CTRL_W  head control bits; all-zero whenever out_valid=0
//  occupancy    out  2       entries held: 0, 1, 2 (2 only when SKID=1)
//  stall_count  out  CNT_W   cycles with out_valid & !out_ready, saturating
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_ctrl=0, occupancy=0, stall_count=0, state EMPTY.
//  Latency: an accepted entry appears on out_* the next cycle (1 cycle, either SKID mode).
//  SKID=0: in_ready = out_ready | ~out_valid (comb). Accept -> main<=in, valid<=1;
//   out fire without accept -> valid<=0, ctrl<=0.
//  SKID=1: in_ready = ~skid_valid (registered only). States on (main_v, skid_v):
//   EMPTY: accept -> ONE (main<=in).
//   ONE: accept & out fire -> ONE (main<=in); accept only -> FULL (skid<=in);
//        out fire only -> EMPTY (ctrl<=0).
//   FULL: in_ready=0; out fire -> ONE (main<=skid, skid_v<=0); else hold.
//  Ordering strictly FIFO; payload and ctrl never change while out_valid & ~out_ready.
//  flush: next state EMPTY, all ctrl regs zeroed, occupancy 0; dominates any accept or
//   out fire in the same cycle; in_ready does not depend on flush; an entry handshaked
//   in the flush cycle is dropped. Data regs need not clear on flush.
//  stall_count: +1 per cycle with out_valid & ~out_ready; holds at 2^CNT_W-1;
//   cleared only by rst; flush does not clear it.
//  rst mid-operation: immediate async clear of all outputs; first accept after release
//   behaves as from EMPTY.
//  in_valid=0 with in_ready=1: no state change. X on in_data while in_valid=0 never
//   propagates to out_data.
// STRUCTURE
//  pipe_pkg: state enum {EMPTY, ONE, FULL}; WB ctrl bit indices CTRL_BRANCH=0, CTRL_J=1,
//   CTRL_JMEM=2, CTRL_STW=3, CTRL_REGWRITE=4, CTRL_ANDG=5; WORD_W=20; WB_DATA_W=180.
//  Sub-module pipe_sat_counter (WIDTH, inc, rst -> count) for stall_count.
//  SKID selected by generate; SKID=0 has no skid registers and no FULL state.
// TESTING
//  1 Reset: assert rst mid-stream with 2 entries held -> all outputs 0 immediately, same cycle.
//  2 Streaming, out_ready=1, 10 back-to-back entries 0x00001..0x0000A -> same order out,
//    1-cycle latency, in_ready stays 1, occupancy stays 1.
//  3 SKID=1 backpressure: out_ready=0, send A,B,C -> A,B accepted, occupancy=2, in_ready=0,
//    C held upstream; release -> A,B,C out in order, stall_count = number of stalled cycles.
//  4 Flush while FULL with ctrl=6'b010000 (regwrite) and in_valid=1 -> next cycle
//    out_valid=0, out_ctrl=0, occupancy=0; presented entry dropped, not output.
//  5 SKID=0 vs SKID=1 on identical random valid/ready traffic (1000 items) -> identical
//    output sequences; scoreboard shows no loss or duplication.
//  6 CNT_W=4, hold out_valid & ~out_ready for 20 cycles -> stall_count sticks at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the pipeline stage registers:
//               stage occupancy state, WB control-bit layout, datapath widths.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Stage occupancy: main entry only, or main plus skid entry.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // WB-stage control bit positions.
    localparam int CTRL_BRANCH   = 0;
    localparam int CTRL_J        = 1;
    localparam int CTRL_JMEM     = 2;
    localparam int CTRL_STW      = 3;
    localparam int CTRL_REGWRITE = 4;
    localparam int CTRL_ANDG     = 5;

    // Datapath widths: nine 20-bit fields travel through the WB stage.
    localparam int WORD_W    = 20;
    localparam int WB_DATA_W = 9 * WORD_W;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : pipe_sat_counter
// Description : Up-counter that sticks at its all-ones value; cleared by rst.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] C_MAX = '1;

    logic [WIDTH-1:0] r_count;

    // Count requested cycles, holding once the maximum is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != C_MAX)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule : pipe_sat_counter
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Valid/ready pipeline stage register with flush, optional
//               2-entry skid buffer (registered ready) and a saturating
//               backpressure-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int CTRL_W = CTRL_ANDG + 1,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_count
);

    logic              w_in_ready;
    logic              w_out_valid;
    logic [DATA_W-1:0] w_out_data;
    logic [CTRL_W-1:0] w_out_ctrl;
    logic [1:0]        w_occupancy;
    logic              w_accept;
    logic              w_fire;

    assign w_accept = in_valid & w_in_ready;
    assign w_fire   = w_out_valid & out_ready;

    if (SKID == 0) begin : g_single
        logic              r_valid;
        logic [DATA_W-1:0] r_data;
        logic [CTRL_W-1:0] r_ctrl;

        // Ready passes straight through from downstream when occupied.
        assign w_in_ready = out_ready | ~r_valid;

        // Single holding register; ctrl is zeroed whenever the entry leaves.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_data  <= '0;
                r_ctrl  <= '0;
            end else if (flush) begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
                r_data  <= in_data;
                r_ctrl  <= in_ctrl;
            end else if (w_fire) begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
            end
        end

        assign w_out_valid = r_valid;
        assign w_out_data  = r_data;
        assign w_out_ctrl  = r_ctrl;
        assign w_occupancy = {1'b0, r_valid};
    end else begin : g_skid
        state_t            r_state;
        state_t            w_state_nxt;
        logic              w_load_main_in;
        logic              w_load_main_skid;
        logic              w_load_skid;
        logic              w_clr_ctrl;
        logic [DATA_W-1:0] r_main_data;
        logic [CTRL_W-1:0] r_main_ctrl;
        logic [DATA_W-1:0] r_skid_data;
        logic [CTRL_W-1:0] r_skid_ctrl;

        // Ready comes only from the state register, never from out_ready.
        assign w_in_ready = (r_state != FULL);

        // Next state and register-load strobes; flush overrides everything.
        always_comb begin
            w_state_nxt      = r_state;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
            w_clr_ctrl       = 1'b0;
            if (flush) begin
                w_state_nxt = EMPTY;
                w_clr_ctrl  = 1'b1;
            end else begin
                case (r_state)
                    EMPTY: begin
                        if (w_accept) begin
                            w_state_nxt    = ONE;
                            w_load_main_in = 1'b1;
                        end
                    end
                    ONE: begin
                        if (w_accept && w_fire) begin
                            w_load_main_in = 1'b1;
                        end else if (w_accept) begin
                            w_state_nxt = FULL;
                            w_load_skid = 1'b1;
                        end else if (w_fire) begin
                            w_state_nxt = EMPTY;
                            w_clr_ctrl  = 1'b1;
                        end
                    end
                    FULL: begin
                        if (w_fire) begin
                            w_state_nxt      = ONE;
                            w_load_main_skid = 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = EMPTY;
                        w_clr_ctrl  = 1'b1;
                    end
                endcase
            end
        end

        // State register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= EMPTY;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        // Main/skid payload registers driven by the load strobes.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_main_data <= '0;
                r_main_ctrl <= '0;
                r_skid_data <= '0;
                r_skid_ctrl <= '0;
            end else begin
                if (w_clr_ctrl) begin
                    r_main_ctrl <= '0;
                    r_skid_ctrl <= '0;
                end
                if (w_load_main_in) begin
                    r_main_data <= in_data;
                    r_main_ctrl <= in_ctrl;
                end
                if (w_load_main_skid) begin
                    r_main_data <= r_skid_data;
                    r_main_ctrl <= r_skid_ctrl;
                    r_skid_ctrl <= '0;
                end
                if (w_load_skid) begin
                    r_skid_data <= in_data;
                    r_skid_ctrl <= in_ctrl;
                end
            end
        end

        // Entry count decoded from the state.
        always_comb begin
            case (r_state)
                ONE:     w_occupancy = 2'd1;
                FULL:    w_occupancy = 2'd2;
                default: w_occupancy = 2'd0;
            endcase
        end

        assign w_out_valid = (r_state != EMPTY);
        assign w_out_data  = r_main_data;
        assign w_out_ctrl  = r_main_ctrl;
    end

    pipe_sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_out_valid & ~out_ready),
        .o_count (stall_count)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = w_out_data;
    assign out_ctrl  = w_out_ctrl;
    assign occupancy = w_occupancy;

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg (SKID=0, SKID=1 and a
//               narrow-counter instance) against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int DW = 180;
    localparam int CW = 6;
    localparam int N  = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush;
    logic iv, ordy, iv4, ordy4;
    logic [DW-1:0] d0, d1, d4;
    logic [CW-1:0] c0, c1, c4;

    logic ir0, ov0, ir1, ov1, ir4, ov4;
    logic [DW-1:0] od0, od1, od4;
    logic [CW-1:0] oc0, oc1, oc4;
    logic [1:0] occ0, occ1, occ4;
    logic [15:0] sc0, sc1;
    logic [3:0] sc4;

    int errors = 0;
    int checks = 0;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv), .in_ready(ir0),
        .in_data(d0), .in_ctrl(c0), .out_valid(ov0), .out_ready(ordy),
        .out_data(od0), .out_ctrl(oc0), .occupancy(occ0), .stall_count(sc0));

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv), .in_ready(ir1),
        .in_data(d1), .in_ctrl(c1), .out_valid(ov1), .out_ready(ordy),
        .out_data(od1), .out_ctrl(oc1), .occupancy(occ1), .stall_count(sc1));

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv4), .in_ready(ir4),
        .in_data(d4), .in_ctrl(c4), .out_valid(ov4), .out_ready(ordy4),
        .out_data(od4), .out_ctrl(oc4), .occupancy(occ4), .stall_count(sc4));

    function automatic logic [DW-1:0] mk_data(input int k);
        logic [DW-1:0] r;
        for (int j = 0; j < 9; j++) r[j*20 +: 20] = 20'(k * 9 + j + 1) ^ 20'h5A5A5;
        return r;
    endfunction

    function automatic logic [CW-1:0] mk_ctrl(input int k);
        return CW'(k * 37 + 5);
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        return DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; iv = 1'b0; ordy = 1'b0; iv4 = 1'b0; ordy4 = 1'b0;
        d0 = '0; d1 = '0; d4 = '0; c0 = '0; c1 = '0; c4 = '0;
        @(negedge clk);
        checks++;
        if ({ov1, occ1, oc1, sc1} !== '0 || od1 !== '0) begin
            errors++;
            $display("FAIL reset_state_skid1: valid=%b occ=%0d ctrl=%b stall=%0d data=%h required all 0", ov1, occ1, oc1, sc1, od1);
        end
        checks++;
        if ({ov0, occ0, oc0, sc0, ov4, sc4} !== '0 || od0 !== '0) begin
            errors++;
            $display("FAIL reset_state_others: v0=%b occ0=%0d ctrl0=%b v4=%b stall4=%0d required all 0", ov0, occ0, oc0, ov4, sc4);
        end
        rst = 1'b0;
        next_cycle();
        iv = 1'b1; d1 = mk_data(100); c1 = mk_ctrl(100); d0 = d1; c0 = c1;
        next_cycle();
        d1 = mk_data(101); c1 = mk_ctrl(101); d0 = d1; c0 = c1;
        next_cycle();
        iv = 1'b0;
        @(negedge clk);
        checks++;
        if (occ1 !== 2'd2 || ov1 !== 1'b1 || od1 !== mk_data(100) || sc1 !== 16'd1) begin
            errors++;
            $display("FAIL pre_reset_full: occ=%0d valid=%b stall=%0d required occ=2 valid=1 stall=1", occ1, ov1, sc1);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ov1, occ1, oc1, sc1} !== '0 || od1 !== '0 || ir1 !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_skid1: valid=%b occ=%0d ctrl=%b stall=%0d in_ready=%b required 0,0,0,0,1", ov1, occ1, oc1, sc1, ir1);
        end
        checks++;
        if ({ov0, occ0, oc0} !== '0 || od0 !== '0) begin
            errors++;
            $display("FAIL async_reset_skid0: valid=%b occ=%0d ctrl=%b required all 0", ov0, occ0, oc0);
        end
        next_cycle();
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_streaming();
        ordy = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            iv = 1'b1; d1 = DW'(k); c1 = mk_ctrl(k); d0 = d1; c0 = c1;
            @(negedge clk);
            checks++;
            if (ir1 !== 1'b1 || ir0 !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready k=%0d: in_ready1=%b in_ready0=%b required 1", k, ir1, ir0);
            end
            checks++;
            if (k == 1) begin
                if (ov1 !== 1'b0 || occ1 !== 2'd0) begin
                    errors++;
                    $display("FAIL stream_first: valid=%b occ=%0d required 0 0", ov1, occ1);
                end
            end else if (ov1 !== 1'b1 || od1 !== DW'(k - 1) || oc1 !== mk_ctrl(k - 1) || occ1 !== 2'd1 || od0 !== DW'(k - 1)) begin
                errors++;
                $display("FAIL stream_out k=%0d: valid=%b data1=%h data0=%h occ=%0d required data=%0d occ=1", k, ov1, od1, od0, occ1, k - 1);
            end
            next_cycle();
        end
        iv = 1'b0;
        @(negedge clk);
        checks++;
        if (ov1 !== 1'b1 || od1 !== DW'(10) || oc1 !== mk_ctrl(10) || occ1 !== 2'd1) begin
            errors++;
            $display("FAIL stream_last: valid=%b data=%h occ=%0d required data=a occ=1", ov1, od1, occ1);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (ov1 !== 1'b0 || oc1 !== '0 || occ1 !== 2'd0 || ov0 !== 1'b0 || oc0 !== '0) begin
            errors++;
            $display("FAIL stream_drain: valid1=%b ctrl1=%b occ1=%0d valid0=%b ctrl0=%b required all 0", ov1, oc1, occ1, ov0, oc0);
        end
        next_cycle();
    endtask

    task automatic test_backpressure();
        int got[$];
        bit taken;
        int idx;
        localparam int HOLD = 4;
        do_reset();
        ordy = 1'b0; iv = 1'b1; d1 = mk_data(200); c1 = mk_ctrl(200); d0 = d1; c0 = c1;
        @(negedge clk);
        checks++;
        if (ir1 !== 1'b1 || ov1 !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept_a: in_ready=%b valid=%b required 1 0", ir1, ov1);
        end
        next_cycle();
        d1 = mk_data(201); c1 = mk_ctrl(201); d0 = d1; c0 = c1;
        @(negedge clk);
        checks++;
        if (ir1 !== 1'b1 || ov1 !== 1'b1 || od1 !== mk_data(200) || occ1 !== 2'd1) begin
            errors++;
            $display("FAIL bp_accept_b: in_ready=%b valid=%b occ=%0d required 1 1 1", ir1, ov1, occ1);
        end
        next_cycle();
        d1 = mk_data(202); c1 = mk_ctrl(202); d0 = d1; c0 = c1;
        for (int i = 0; i < HOLD; i++) begin
            @(negedge clk);
            checks++;
            if (occ1 !== 2'd2 || ir1 !== 1'b0 || od1 !== mk_data(200) || oc1 !== mk_ctrl(200) || sc1 !== 16'(1 + i)) begin
                errors++;
                $display("FAIL bp_full_hold i=%0d: occ=%0d in_ready=%b stall=%0d required occ=2 in_ready=0 stall=%0d", i, occ1, ir1, sc1, 1 + i);
            end
            next_cycle();
        end
        ordy = 1'b1;
        taken = 1'b0;
        for (int cyc = 0; cyc < 12 && got.size() < 3; cyc++) begin
            @(negedge clk);
            if (ov1) begin
                idx = -1;
                for (int j = 0; j < 3; j++) if (od1 === mk_data(200 + j)) idx = j;
                got.push_back(idx);
            end
            if (iv && ir1) taken = 1'b1;
            next_cycle();
            if (taken) iv = 1'b0;
        end
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL bp_drain_count: got %0d entries required 3", got.size());
        end
        for (int j = 0; j < got.size() && j < 3; j++) begin
            checks++;
            if (got[j] != j) begin
                errors++;
                $display("FAIL bp_order pos=%0d: got entry %0d required %0d", j, got[j], j);
            end
        end
        checks++;
        if (sc1 !== 16'(1 + HOLD)) begin
            errors++;
            $display("FAIL bp_stall_count: got %0d required %0d", sc1, 1 + HOLD);
        end
        iv = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        ordy = 1'b0; iv = 1'b1; d1 = mk_data(300); c1 = 6'b010000; d0 = d1; c0 = c1;
        next_cycle();
        d1 = mk_data(301); d0 = d1;
        next_cycle();
        d1 = mk_data(302); d0 = d1; flush = 1'b1;
        @(negedge clk);
        checks++;
        if (ir1 !== 1'b0 || occ1 !== 2'd2 || oc1 !== 6'b010000) begin
            errors++;
            $display("FAIL flush_pre: in_ready=%b occ=%0d ctrl=%b required 0 2 010000", ir1, occ1, oc1);
        end
        next_cycle();
        flush = 1'b0; iv = 1'b0;
        @(negedge clk);
        checks++;
        if (ov1 !== 1'b0 || oc1 !== '0 || occ1 !== 2'd0 || ir1 !== 1'b1 || sc1 !== 16'd2) begin
            errors++;
            $display("FAIL flush_full: valid=%b ctrl=%b occ=%0d in_ready=%b stall=%0d required 0 0 0 1 2", ov1, oc1, occ1, ir1, sc1);
        end
        iv = 1'b1; d1 = mk_data(303); d0 = d1;
        next_cycle();
        d1 = mk_data(304); d0 = d1; flush = 1'b1;
        @(negedge clk);
        checks++;
        if (ir1 !== 1'b1 || ov1 !== 1'b1) begin
            errors++;
            $display("FAIL flush_one_pre: in_ready=%b valid=%b required 1 1", ir1, ov1);
        end
        next_cycle();
        flush = 1'b0; iv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ov1 !== 1'b0 || occ1 !== 2'd0 || oc1 !== '0) begin
                errors++;
                $display("FAIL flush_drop i=%0d: valid=%b occ=%0d ctrl=%b required 0 0 0", i, ov1, occ1, oc1);
            end
            next_cycle();
        end
        ordy = 1'b1; iv = 1'b1; d1 = mk_data(305); c1 = mk_ctrl(305); d0 = d1; c0 = c1;
        next_cycle();
        iv = 1'b0;
        @(negedge clk);
        checks++;
        if (ov1 !== 1'b1 || od1 !== mk_data(305) || oc1 !== mk_ctrl(305)) begin
            errors++;
            $display("FAIL flush_recover: valid=%b data=%h required 1 %h", ov1, od1, mk_data(305));
        end
        next_cycle();
    endtask

    task automatic test_random_equiv();
        int m0[$], m1[$], out0[$], out1[$];
        int s0 = 0, s1 = 0, cyc = 0, bad = 0;
        bit e_ir0, e_ir1;
        do_reset();
        while ((out0.size() < N || out1.size() < N) && cyc < 20000) begin
            iv = (($urandom() % 10) < 7);
            ordy = (($urandom() % 10) < 7);
            d0 = iv ? mk_data(s0) : rnd_data();
            c0 = iv ? mk_ctrl(s0) : CW'($urandom());
            d1 = iv ? mk_data(s1) : rnd_data();
            c1 = iv ? mk_ctrl(s1) : CW'($urandom());
            @(negedge clk);
            e_ir0 = ordy || (m0.size() == 0);
            e_ir1 = (m1.size() < 2);
            checks++;
            if ({ir0, ov0, occ0} !== {e_ir0, m0.size() > 0, 2'(m0.size())}) begin
                errors++;
                $display("FAIL rnd_hs0 cyc=%0d: rdy/val/occ=%b%b/%0d required %b%b/%0d", cyc, ir0, ov0, occ0, e_ir0, m0.size() > 0, m0.size());
            end
            checks++;
            if ({ir1, ov1, occ1} !== {e_ir1, m1.size() > 0, 2'(m1.size())}) begin
                errors++;
                $display("FAIL rnd_hs1 cyc=%0d: rdy/val/occ=%b%b/%0d required %b%b/%0d", cyc, ir1, ov1, occ1, e_ir1, m1.size() > 0, m1.size());
            end
            checks++;
            if (m0.size() > 0 ? (od0 !== mk_data(m0[0]) || oc0 !== mk_ctrl(m0[0])) : (oc0 !== '0)) begin
                errors++;
                $display("FAIL rnd_pay0 cyc=%0d: data=%h ctrl=%b required item %0d", cyc, od0, oc0, m0.size() > 0 ? m0[0] : -1);
            end
            checks++;
            if (m1.size() > 0 ? (od1 !== mk_data(m1[0]) || oc1 !== mk_ctrl(m1[0])) : (oc1 !== '0)) begin
                errors++;
                $display("FAIL rnd_pay1 cyc=%0d: data=%h ctrl=%b required item %0d", cyc, od1, oc1, m1.size() > 0 ? m1[0] : -1);
            end
            if (m0.size() > 0 && ordy) out0.push_back(m0.pop_front());
            if (iv && e_ir0) begin m0.push_back(s0); s0++; end
            if (m1.size() > 0 && ordy) out1.push_back(m1.pop_front());
            if (iv && e_ir1) begin m1.push_back(s1); s1++; end
            next_cycle();
            cyc++;
        end
        iv = 1'b0; ordy = 1'b0;
        checks++;
        if (out0.size() < N || out1.size() < N) begin
            errors++;
            $display("FAIL rnd_timeout: out0=%0d out1=%0d required %0d each within 20000 cycles", out0.size(), out1.size(), N);
        end
        for (int i = 0; i < N && i < out0.size() && i < out1.size(); i++)
            if (out0[i] != out1[i] || out1[i] != i) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rnd_seq_identical: %0d positions differ required 0", bad);
        end
    endtask

    task automatic test_sat_counter();
        do_reset();
        ordy4 = 1'b0; iv4 = 1'b1; d4 = mk_data(7); c4 = mk_ctrl(7);
        next_cycle();
        iv4 = 1'b0; d4 = rnd_data();
        for (int n = 0; n <= 20; n++) begin
            @(negedge clk);
            checks++;
            if (sc4 !== 4'((n > 15) ? 15 : n)) begin
                errors++;
                $display("FAIL sat_count n=%0d: got %0d required %0d", n, sc4, (n > 15) ? 15 : n);
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (ov4 !== 1'b1 || od4 !== mk_data(7) || oc4 !== mk_ctrl(7) || occ4 !== 2'd1) begin
            errors++;
            $display("FAIL sat_hold_payload: valid=%b occ=%0d ctrl=%b required 1 1 %b", ov4, occ4, oc4, mk_ctrl(7));
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_random_equiv();
        test_sat_counter();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_pipe_stage_reg
`default_nettype wire
